hms_timer: RTL

HMS_TIMER -- requirements
Module: hms_timer

---
 rtl/hms_pkg.sv | 31 +++
 rtl/hms_timer_tick_gen.sv | 26 ++
 rtl/hms_timer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hms_pkg.sv
// Shared encodings and field limits for the hours/minutes/seconds timer.
package hms_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        SEL_SEC  = 2'b00,
        SEL_MIN  = 2'b01,
        SEL_HR   = 2'b10,
        SEL_NONE = 2'b11
    } adj_sel_t;

    localparam logic [6:0] SEC_MAX = 7'd59;
    localparam logic [6:0] MIN_MAX = 7'd59;

    // Single-field increment/decrement with wrap between 0 and max.
    function automatic logic [6:0] step_field(input logic [6:0] v,
                                              input logic [6:0] max,
                                              input logic       up);
        if (up)
            return (v == max) ? 7'd0 : v + 7'd1;
        else
            return (v == 7'd0) ? max : v - 7'd1;
    endfunction

endpackage

// File: rtl/hms_timer_tick_gen.sv
// Prescaler: counts enabled cycles 0..DIV-1 and strobes tick on the last one.
module tick_gen #(
    parameter int unsigned DIV = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_50) begin
        if (reset || clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/hms_timer.sv
// Stopwatch / countdown timer with HH:MM:SS registers, field editing and a 1-s prescaler.
module hms_timer
    import hms_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned HOURS_MAX = 99
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       mode,
    input  logic       run,
    input  logic       clear,
    input  logic       adj_up,
    input  logic       adj_dn,
    input  logic [1:0] adj_sel,
    output logic [6:0] seconds,
    output logic [6:0] minutes,
    output logic [6:0] hours,
    output logic       tick,
    output logic       done,
    output logic [1:0] state
);

    localparam logic [6:0] HR_MAX = 7'(HOURS_MAX);

    state_t     cur, nxt;
    logic       mode_q, mode_d;
    logic [6:0] sec_q, min_q, hr_q;
    logic [6:0] sec_d, min_d, hr_d;
    logic       run_en, presc_clr, tick_w;

    // The prescaler only advances while actually running, so dropping run freezes it.
    assign run_en    = (cur == ST_RUN) && run;
    assign presc_clr = (cur == ST_IDLE) || clear;

    tick_gen #(.DIV(CLK_HZ)) u_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .clr      (presc_clr),
        .en       (run_en),
        .tick     (tick_w)
    );

    logic       time_zero;
    logic       cnt_up, sec_wrap, min_wrap;
    logic [6:0] sec_t, min_t, hr_t;
    logic       edit_ok;
    logic [6:0] sec_e, min_e, hr_e;

    assign time_zero = (sec_q == 7'd0) && (min_q == 7'd0) && (hr_q == 7'd0);

    always_comb begin
        cnt_up   = ~mode_q;
        sec_wrap = cnt_up ? (sec_q == SEC_MAX) : (sec_q == 7'd0);
        min_wrap = sec_wrap && (cnt_up ? (min_q == MIN_MAX) : (min_q == 7'd0));
        sec_t    = step_field(sec_q, SEC_MAX, cnt_up);
        min_t    = sec_wrap ? step_field(min_q, MIN_MAX, cnt_up) : min_q;
        hr_t     = min_wrap ? step_field(hr_q, HR_MAX, cnt_up) : hr_q;
    end

    always_comb begin
        edit_ok = (adj_up ^ adj_dn) && (adj_sel_t'(adj_sel) != SEL_NONE);
        sec_e   = sec_q;
        min_e   = min_q;
        hr_e    = hr_q;
        if (edit_ok) begin
            unique case (adj_sel_t'(adj_sel))
                SEL_SEC:  sec_e = step_field(sec_q, SEC_MAX, adj_up);
                SEL_MIN:  min_e = step_field(min_q, MIN_MAX, adj_up);
                SEL_HR:   hr_e  = step_field(hr_q, HR_MAX, adj_up);
                SEL_NONE: ;
            endcase
        end
    end

    always_comb begin
        nxt    = cur;
        mode_d = mode_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hr_d   = hr_q;
        if (clear) begin
            nxt   = ST_IDLE;
            sec_d = '0;
            min_d = '0;
            hr_d  = '0;
        end else begin
            unique case (cur)
                ST_IDLE: begin
                    sec_d = sec_e;
                    min_d = min_e;
                    hr_d  = hr_e;
                    if (run && (!mode || !time_zero)) begin
                        nxt    = ST_RUN;
                        mode_d = mode;
                    end
                end
                ST_RUN: begin
                    if (tick_w) begin
                        sec_d = sec_t;
                        min_d = min_t;
                        hr_d  = hr_t;
                        if (mode_q && (sec_t == 7'd0) && (min_t == 7'd0) && (hr_t == 7'd0))
                            nxt = ST_DONE;
                    end else if (!run) begin
                        nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    sec_d = sec_e;
                    min_d = min_e;
                    hr_d  = hr_e;
                    if (run)
                        nxt = ST_RUN;
                end
                ST_DONE: begin
                    if (!run)
                        nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cur    <= ST_IDLE;
            mode_q <= 1'b0;
            sec_q  <= '0;
            min_q  <= '0;
            hr_q   <= '0;
        end else begin
            cur    <= nxt;
            mode_q <= mode_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hr_q   <= hr_d;
        end
    end

    assign seconds = sec_q;
    assign minutes = min_q;
    assign hours   = hr_q;
    assign tick    = tick_w;
    assign done    = (cur == ST_DONE);
    assign state   = cur;

endmodule
